// File: rtl/key_scan_debounce.sv
// Four-channel push-button front end: synchronises the active-low KEY pins, debounces
// each one and turns the clean level into press, release, long-press and auto-repeat events.
module key_scan_debounce #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic              FPGA_CLK,
    input  logic              RESET,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] KEY_LEVEL,
    output logic [N_KEYS-1:0] KEY_PRESS,
    output logic [N_KEYS-1:0] KEY_RELEASE,
    output logic [N_KEYS-1:0] KEY_LONG,
    output logic [N_KEYS-1:0] KEY_REPEAT
);

    localparam int DW       = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HW       = $clog2(HOLD_MAX);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_LONG
    } state_e;

    for (genvar g = 0; g < N_KEYS; g++) begin : gKey
        logic          sync1_q, sync2_q;
        logic          pressedRaw;
        logic          accept;
        logic [DW-1:0] debCnt_q, debCnt_d;
        logic          level_q, level_d;
        state_e        state_q, state_d;
        logic [HW-1:0] holdCnt_q, holdCnt_d;
        logic          press_q, press_d;
        logic          rel_q, rel_d;
        logic          long_q, long_d;
        logic          rpt_q, rpt_d;

        assign pressedRaw = ~sync2_q;
        assign accept     = (pressedRaw != level_q) && (debCnt_q == DEB_LAST);

        // Any cycle where the synchronised key agrees with the accepted level restarts the count.
        always_comb begin
            debCnt_d = '0;
            level_d  = level_q;
            if (pressedRaw != level_q) begin
                if (debCnt_q == DEB_LAST) begin
                    level_d = ~level_q;
                end else begin
                    debCnt_d = debCnt_q + DW'(1);
                end
            end
        end

        // An accepted level change takes priority over hold timing, so a release
        // landing on a long-press or repeat boundary suppresses those events.
        always_comb begin
            state_d   = state_q;
            holdCnt_d = holdCnt_q;
            press_d   = 1'b0;
            rel_d     = 1'b0;
            long_d    = long_q;
            rpt_d     = 1'b0;
            if (accept && !level_q) begin
                state_d   = ST_HELD;
                holdCnt_d = '0;
                press_d   = 1'b1;
            end else if (accept && level_q) begin
                state_d   = ST_IDLE;
                holdCnt_d = '0;
                rel_d     = 1'b1;
                long_d    = 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        holdCnt_d = '0;
                    end
                    ST_HELD: begin
                        if (holdCnt_q == LONG_LAST) begin
                            state_d   = ST_LONG;
                            holdCnt_d = '0;
                            long_d    = 1'b1;
                            rpt_d     = 1'b1;
                        end else begin
                            holdCnt_d = holdCnt_q + HW'(1);
                        end
                    end
                    ST_LONG: begin
                        if (holdCnt_q == REP_LAST) begin
                            holdCnt_d = '0;
                            rpt_d     = 1'b1;
                        end else begin
                            holdCnt_d = holdCnt_q + HW'(1);
                        end
                    end
                    default: begin
                        state_d   = ST_IDLE;
                        holdCnt_d = '0;
                        long_d    = 1'b0;
                    end
                endcase
            end
        end

        always_ff @(posedge FPGA_CLK) begin
            if (RESET) begin
                sync1_q   <= 1'b1;
                sync2_q   <= 1'b1;
                debCnt_q  <= '0;
                level_q   <= 1'b0;
                state_q   <= ST_IDLE;
                holdCnt_q <= '0;
                press_q   <= 1'b0;
                rel_q     <= 1'b0;
                long_q    <= 1'b0;
                rpt_q     <= 1'b0;
            end else begin
                sync1_q   <= KEY[g];
                sync2_q   <= sync1_q;
                debCnt_q  <= debCnt_d;
                level_q   <= level_d;
                state_q   <= state_d;
                holdCnt_q <= holdCnt_d;
                press_q   <= press_d;
                rel_q     <= rel_d;
                long_q    <= long_d;
                rpt_q     <= rpt_d;
            end
        end

        assign KEY_LEVEL[g]   = level_q;
        assign KEY_PRESS[g]   = press_q;
        assign KEY_RELEASE[g] = rel_q;
        assign KEY_LONG[g]    = long_q;
        assign KEY_REPEAT[g]  = rpt_q;
    end

endmodule

// File: tb/tb_key_scan_debounce.sv
// Scoreboard bench for key_scan_debounce: a timing-arithmetic reference model queues the
// expected outputs each edge and a monitor compares them against the DUT on the falling edge.
module tb_key_scan_debounce;

    localparam int NK  = 4;
    localparam int DEB = 8;
    localparam int LNG = 40;
    localparam int REP = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NK-1:0]   key = '1;
    logic [NK-1:0]   lvlO, pressO, relO, longO, rptO;

    typedef struct packed {
        logic [NK-1:0] lvl;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] lng;
        logic [NK-1:0] rpt;
    } exp_t;

    exp_t sbQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   edgeN       = 0;

    always #5 clk = ~clk;

    key_scan_debounce #(
        .N_KEYS         (NK),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LNG),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .FPGA_CLK   (clk),
        .RESET      (rst),
        .KEY        (key),
        .KEY_LEVEL  (lvlO),
        .KEY_PRESS  (pressO),
        .KEY_RELEASE(relO),
        .KEY_LONG   (longO),
        .KEY_REPEAT (rptO)
    );

    // Reference model: the key seen by the debouncer is the pin value two edges old;
    // a level change is accepted once that value has differed from the level for DEB
    // consecutive edges, and long/repeat times are offsets from the press edge.
    logic [NK-1:0] mD1, mD2, mS, mLvl;
    int            sStart[NK];
    int            pressEdge[NK];

    task automatic modelStep();
        exp_t          e;
        logic [NK-1:0] sNow;
        int            d;
        e = '0;
        if (rst) begin
            mD1  = '1;
            mD2  = '1;
            mS   = '0;
            mLvl = '0;
            for (int i = 0; i < NK; i++) begin
                sStart[i]    = edgeN;
                pressEdge[i] = 0;
            end
        end else begin
            sNow = ~mD2;
            mD2  = mD1;
            mD1  = key;
            for (int i = 0; i < NK; i++) begin
                if (sNow[i] != mS[i]) sStart[i] = edgeN;
                if (sNow[i] != mLvl[i] && (edgeN - sStart[i] + 1) >= DEB) begin
                    mLvl[i] = sNow[i];
                    if (sNow[i]) begin
                        e.press[i]   = 1'b1;
                        pressEdge[i] = edgeN;
                    end else begin
                        e.rel[i] = 1'b1;
                    end
                end
                if (mLvl[i]) begin
                    d = edgeN - pressEdge[i];
                    if (d >= LNG) begin
                        e.lng[i] = 1'b1;
                        if (((d - LNG) % REP) == 0) e.rpt[i] = 1'b1;
                    end
                end
            end
            mS = sNow;
        end
        e.lvl = mLvl;
        sbQ.push_back(e);
        edgeN++;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    task automatic checkOutput(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s at edge %0d: got %b, expected %b", name, edgeN, act, exp);
        end
    endtask

    // Monitor: every registered output is presented each cycle, so one entry is consumed per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput("KEY_LEVEL",   lvlO,   e.lvl);
                checkOutput("KEY_PRESS",   pressO, e.press);
                checkOutput("KEY_RELEASE", relO,   e.rel);
                checkOutput("KEY_LONG",    longO,  e.lng);
                checkOutput("KEY_REPEAT",  rptO,   e.rpt);
            end
        end
    end

    task automatic applyStimulus(input logic [NK-1:0] k, input int cycles);
        key = k;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic applyReset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [NK-1:0] rk;
        int            len;
        rst = 1'b1;
        key = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] idle after reset");
        applyStimulus(4'b1111, 100);

        $display("[TB] short press on key 0");
        applyStimulus(4'b1110, 30);
        applyStimulus(4'b1111, 20);

        $display("[TB] bouncing key 1");
        for (int i = 0; i < 10; i++) applyStimulus((i % 2 == 0) ? 4'b1101 : 4'b1111, 3);
        applyStimulus(4'b1111, 20);
        applyStimulus(4'b1101, 20);
        applyStimulus(4'b1111, 20);

        $display("[TB] long press with repeats on key 2");
        applyStimulus(4'b1011, 100);
        applyStimulus(4'b1111, 20);

        $display("[TB] all keys pressed, staggered release");
        applyStimulus(4'b0000, 60);
        applyStimulus(4'b0001, 3);
        applyStimulus(4'b0011, 4);
        applyStimulus(4'b0111, 5);
        applyStimulus(4'b1111, 20);

        $display("[TB] reset while key 3 held");
        applyStimulus(4'b0111, 45);
        applyReset(2);
        applyStimulus(4'b0111, 70);
        applyStimulus(4'b1111, 20);

        $display("[TB] randomized key activity");
        for (int s = 0; s < 40; s++) begin
            rk  = NK'($urandom);
            len = int'($urandom_range(1, 60));
            if ($urandom_range(0, 9) == 0) applyReset(int'($urandom_range(1, 3)));
            applyStimulus(rk, len);
        end
        applyStimulus(4'b1111, 30);

        #2;
        testsRun++;
        if (sbQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboardDrain: %0d entries left, expected 0", sbQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
